// File: rtl/calc_alu_seq.sv
// -----------------------------------------------------------------------------
// calc_alu_seq
//
// Sequential signed arithmetic core feeding the calculator output stage.
// The core accepts two signed two's-complement operands and an opcode, computes
// the result over one or more clock cycles, registers it, and then raises
// load_ou for a single cycle so the display stage can latch the value.
//
//   op 00 : A + B  (1 calc cycle)
//   op 01 : A - B  (1 calc cycle)
//   op 10 : A * B  (shift-add over magnitudes, WIDTH calc cycles)
//   op 11 : A / B  (restoring division over magnitudes, WIDTH calc cycles;
//                   1 calc cycle when B == 0)
//
// Optional build macro: CALC_SAT_EN
//   Undefined (default): an overflowing result wraps to WIDTH bits.
//   Defined: an overflowing result saturates to the most-positive or the
//   most-negative value, chosen by the sign of the true result. The overflow
//   flag is set in both builds. Divide-by-zero behaves the same in both builds.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   operand_a    in   signed operand A, captured on an accepted start
//   operand_b    in   signed operand B, captured on an accepted start
//   op           in   opcode, captured on an accepted start
//   start        in   request; accepted only while idle
//   result       out  registered signed result (holds between operations)
//   load_ou      out  one-cycle pulse marking result valid
//   busy         out  high while calculating and in the load cycle
//   overflow     out  signed result did not fit in WIDTH bits
//   div_by_zero  out  divide with operand_b == 0
//   dbg_state    out  current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: start is a level sampled on the rising edge while the core is
// idle; it is ignored (not queued) in every other state. load_ou rises for
// exactly one cycle after result/overflow/div_by_zero have been updated; the
// output stage needs no ready, it must take the value in that cycle.
// -----------------------------------------------------------------------------
module calc_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [1:0]       op,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             load_ou,
    output logic             busy,
    output logic             overflow,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   VAL_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   VAL_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    // 2^(WIDTH-1) in product width: largest magnitude a negative result may have.
    localparam logic [2*WIDTH-1:0] PROD_HALF = (2*WIDTH)'(1) << (WIDTH - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [1:0]           op_q, op_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;      // sign of the true mul/div result
    logic [WIDTH-1:0]     magb_q, magb_d;    // |B|: divisor
    logic [2*WIDTH-1:0]   acc_q, acc_d;      // mul partial product
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;  // |A| shifted left each step
    logic [WIDTH-1:0]     mplier_q, mplier_d;// |B| shifted right each step
    logic [WIDTH:0]       rem_q, rem_d;      // div partial remainder
    logic [WIDTH-1:0]     quo_q, quo_d;      // dividend bits in, quotient bits out
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 ovf_q, ovf_d;
    logic                 dbz_q, dbz_d;

    // Datapath intermediates
    logic [WIDTH-1:0]     b_eff;
    logic [WIDTH-1:0]     sum;
    logic                 sum_ovf;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [2*WIDTH-1:0]   prod_signed;
    logic                 prod_ovf;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH:0]       rem_nxt;
    logic [WIDTH-1:0]     quo_nxt;
    logic [WIDTH-1:0]     quo_signed;
    logic                 quo_ovf;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] finish_val(input logic             ovf,
                                                     input logic [WIDTH-1:0] wrapped,
                                                     input logic             true_neg);
`ifdef CALC_SAT_EN
        if (ovf) begin
            return true_neg ? VAL_MIN : VAL_MAX;
        end
        return wrapped;
`else
        // Wrapping build: the sign of the true result is not needed.
        logic unused_ok;
        unused_ok = ovf ^ true_neg;
        return wrapped;
`endif
    endfunction

    // Add/sub: subtract is A + ~B + 1, so overflow uses the sign of ~B.
    always_comb begin
        b_eff   = (op_q == OP_SUB) ? ~b_q : b_q;
        sum     = a_q + b_eff + WIDTH'(op_q == OP_SUB);
        sum_ovf = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Multiply step: add the shifted multiplicand when the current multiplier
    // bit is set. The product is formed from magnitudes and signed at the end.
    always_comb begin
        acc_nxt     = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod_signed = neg_q ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;
        prod_ovf    = neg_q ? (acc_nxt > PROD_HALF) : (acc_nxt >= PROD_HALF);
    end

    // Restoring division step: shift in the next dividend bit and keep the
    // trial difference only when it is non-negative.
    always_comb begin
        div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, magb_q};
        if (div_trial[WIDTH]) begin
            rem_nxt = div_shift;
            quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_nxt = div_trial;
            quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
        end
        // A negative quotient of 0 negates to 0, so zero is always +0.
        quo_signed = neg_q ? (~quo_nxt + WIDTH'(1)) : quo_nxt;
        // Only -2^(WIDTH-1) / -1 produces a positive magnitude of 2^(WIDTH-1).
        quo_ovf    = !neg_q && quo_nxt[WIDTH-1];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        magb_d   = magb_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CALC;
                    a_d      = operand_a;
                    b_d      = operand_b;
                    op_d     = op;
                    cnt_d    = '0;
                    neg_d    = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    magb_d   = magnitude(operand_b);
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, magnitude(operand_a)};
                    mplier_d = magnitude(operand_b);
                    rem_d    = '0;
                    quo_d    = magnitude(operand_a);
                end
            end

            CALC: begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        result_d = finish_val(sum_ovf, sum, a_q[WIDTH-1]);
                        ovf_d    = sum_ovf;
                        dbz_d    = 1'b0;
                        state_d  = DONE;
                    end
                    OP_MUL: begin
                        acc_d    = acc_nxt;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        cnt_d    = cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            result_d = finish_val(prod_ovf, prod_signed[WIDTH-1:0], neg_q);
                            ovf_d    = prod_ovf;
                            dbz_d    = 1'b0;
                            state_d  = DONE;
                        end
                    end
                    default: begin // OP_DIV
                        if (b_q == '0) begin
                            result_d = '0;
                            ovf_d    = 1'b0;
                            dbz_d    = 1'b1;
                            state_d  = DONE;
                        end else begin
                            rem_d = rem_nxt;
                            quo_d = quo_nxt;
                            cnt_d = cnt_q + CW'(1);
                            if (cnt_q == CNT_LAST) begin
                                result_d = finish_val(quo_ovf, quo_signed, neg_q);
                                ovf_d    = quo_ovf;
                                dbz_d    = 1'b0;
                                state_d  = DONE;
                            end
                        end
                    end
                endcase
            end

            DONE: begin
                // A start seen here is dropped; the next one is taken in IDLE.
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            magb_q   <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            magb_q   <= magb_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
        end
    end

    assign result      = result_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
    assign load_ou     = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Testbench for calc_alu_seq: directed cases followed by random operations,
// each compared against an integer-arithmetic reference model.
module tb_calc_alu_seq;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [1:0]   op;
    logic         start;
    logic [W-1:0] result;
    logic         load_ou;
    logic         busy;
    logic         overflow;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected results, pushed by the model and popped when load_ou fires.
    logic [W+1:0] exp_q[$];

    calc_alu_seq #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .op          (op),
        .start       (start),
        .result      (result),
        .load_ou     (load_ou),
        .busy        (busy),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {div_by_zero, overflow, result} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [1:0] o,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int sa, sb, t;
        logic [W-1:0] r;
        logic ovf;
        sa = $signed(a);
        sb = $signed(b);
        if (o == 2'b11 && b == '0) return {1'b1, 1'b0, {W{1'b0}}};
        case (o)
            2'b00:   t = sa + sb;
            2'b01:   t = sa - sb;
            2'b10:   t = sa * sb;
            default: t = sa / sb;
        endcase
        ovf = (t > 127) || (t < -128);
        r = t[W-1:0];
`ifdef CALC_SAT_EN
        if (ovf) r = (t < 0) ? 8'h80 : 8'h7F;
`endif
        return {1'b0, ovf, r};
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [W-1:0] b);
        if (o[1] == 1'b0 || (o == 2'b11 && b == '0)) return 2;
        return W + 1;
    endfunction

    // ---------------- driver ----------------
    // Issues one operation starting in the cycle after the next rising edge,
    // optionally toggling start randomly while busy (must be ignored), and
    // checks latency, result, flags and the return to idle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit noise);
        logic [W+1:0] exp;
        int lat, seen;
        exp_q.push_back(model(o, a, b));
        lat = latency(o, b);
        @(posedge clock); #1;
        operand_a = a; operand_b = b; op = o; start = 1'b1;
        seen = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            operand_a = W'($urandom_range(0, 255));
            operand_b = W'($urandom_range(0, 255));
            op        = 2'($urandom_range(0, 3));
            if (i == 1) check("busy_after_start", busy, 1'b1);
            if (load_ou) begin
                seen = i;
                break;
            end
        end
        check("load_latency", seen, lat);
        exp = exp_q.pop_front();
        check("result", result, exp[W-1:0]);
        check("overflow", overflow, exp[W]);
        check("div_by_zero", div_by_zero, exp[W+1]);
        // A start raised during the load cycle must be dropped.
        if (noise) start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("load_single_pulse", load_ou, 1'b0);
        check("idle_after_done", busy, 1'b0);
        check("result_hold", result, exp[W-1:0]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int no_load;
        reset = 1'b1; start = 1'b0; operand_a = '0; operand_b = '0; op = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_result", result, 0);
        check("rst_load", load_ou, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_dbz", div_by_zero, 0);
        reset = 1'b0;

        // Directed cases
        run_op(2'b00, 8'h05, 8'h03, 1'b0);
        run_op(2'b01, 8'h80, 8'h01, 1'b0);
        run_op(2'b10, 8'hF9, 8'h06, 1'b0);
        run_op(2'b10, 8'h10, 8'h10, 1'b0);
        run_op(2'b11, 8'h9C, 8'h07, 1'b0);
        run_op(2'b11, 8'h80, 8'hFF, 1'b0);
        run_op(2'b11, 8'h2A, 8'h00, 1'b1);
        run_op(2'b00, 8'h7F, 8'h01, 1'b1);
        run_op(2'b10, 8'h80, 8'h01, 1'b0);
        run_op(2'b10, 8'h80, 8'hFF, 1'b0);
        run_op(2'b11, 8'h03, 8'hFC, 1'b0);
        run_op(2'b01, 8'h00, 8'h80, 1'b0);

        // Reset in the middle of a multiply, with a stray start during it
        @(posedge clock); #1;
        operand_a = 8'h33; operand_b = 8'h05; op = 2'b10; start = 1'b1;   // cycle 0
        @(posedge clock); #1; start = 1'b0;                                 // cycle 1
        @(posedge clock); #1;                                               // cycle 2
        @(posedge clock); #1; start = 1'b1; op = 2'b00;                     // cycle 3
        @(posedge clock); #1; start = 1'b0;                                 // cycle 4
        check("busy_before_abort", busy, 1'b1);
        @(posedge clock); #1; reset = 1'b1;                                 // cycle 5
        @(posedge clock); #1; reset = 1'b0;
        check("abort_result", result, 0);
        check("abort_busy", busy, 0);
        check("abort_load", load_ou, 0);
        check("abort_overflow", overflow, 0);
        check("abort_dbz", div_by_zero, 0);
        no_load = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (load_ou || busy) no_load++;
        end
        check("abort_no_load", no_load, 0);
        run_op(2'b00, 8'h01, 8'h01, 1'b0);

        // Random operations, with division-by-zero and extremes favoured
        for (int n = 0; n < 60; n++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0: rb = 8'h00;
                1: ra = 8'h80;
                2: rb = 8'hFF;
                default: ;
            endcase
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
